// File: rtl/param_shift_register.sv
// Universal shift register: hold, parallel load, logical shifts, rotates and
// arithmetic shift right, STEP bits per step, op_count steps per accepted op.
module param_shift_register #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_mode,
    input  logic [CNT_W-1:0] op_count,
    input  logic [WIDTH-1:0] load_data,
    input  logic [STEP-1:0]  ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic [STEP-1:0]  ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_NOP2 = 3'b111
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    state_e           state, state_n;
    op_e              mode_q, mode_n;
    logic             dir_q, dir_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             done_q, done_n;

    // Whole-word shifts keep STEP==WIDTH legal: shifting out everything gives
    // the serial fill, rotates wrap back to the same value, ASR smears the sign.
    function automatic logic [WIDTH-1:0] apply_step(
        input op_e              mode,
        input logic [WIDTH-1:0] d,
        input logic [STEP-1:0]  s
    );
        logic [WIDTH-1:0] s_ext;
        logic [WIDTH-1:0] r;
        s_ext = WIDTH'(s);
        case (mode)
            OP_SHL:  r = (d << STEP) | s_ext;
            OP_SHR:  r = (d >> STEP) | (s_ext << (WIDTH - STEP));
            OP_ROL:  r = (d << STEP) | (d >> (WIDTH - STEP));
            OP_ROR:  r = (d >> STEP) | (d << (WIDTH - STEP));
            OP_ASR:  r = $unsigned($signed(d) >>> STEP);
            default: r = d;
        endcase
        return r;
    endfunction

    // State, datapath and latched op context; reset aborts any burst silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mode_q    <= OP_NOP;
            dir_q     <= DIR_LEFT;
            remaining <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            dir_q     <= dir_n;
            remaining <= remaining_n;
            data_q    <= data_n;
            done_q    <= done_n;
        end
    end

    // Next-state logic: accept an op in IDLE (applying step 1 at once), then
    // run the remaining steps in SHIFT ignoring any new requests
    always_comb begin
        state_n     = state;
        mode_n      = mode_q;
        dir_n       = dir_q;
        remaining_n = remaining;
        data_n      = data_q;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op_e'(op_mode))
                        OP_LOAD: begin
                            data_n = load_data;
                            done_n = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: begin
                            mode_n = op_e'(op_mode);
                            dir_n  = (op_e'(op_mode) == OP_SHL || op_e'(op_mode) == OP_ROL)
                                     ? DIR_LEFT : DIR_RIGHT;
                            if (op_count == '0) begin
                                done_n = 1'b1;
                            end else begin
                                data_n = apply_step(op_e'(op_mode), data_q, ser_in);
                                if (op_count == CNT_W'(1)) begin
                                    done_n = 1'b1;
                                end else begin
                                    state_n     = SHIFT;
                                    remaining_n = op_count - CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                            done_n = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                data_n      = apply_step(mode_q, data_q, ser_in);
                remaining_n = remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode: the bits about to leave depend on the last shift direction
    always_comb begin
        op_ready = (state == IDLE);
        busy     = (state == SHIFT);
        done     = done_q;
        data_out = data_q;
        ser_out  = (dir_q == DIR_LEFT) ? data_q[WIDTH-1 -: STEP] : data_q[STEP-1:0];
    end

endmodule

// File: tb/tb_param_shift_register.sv
// Directed self-checking bench for param_shift_register (WIDTH=8, STEP=1 and STEP=2).
module tb_param_shift_register;

    logic       clk;
    logic       reset_n;

    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_mode;
    logic [3:0] op_count;
    logic [7:0] load_data;
    logic       ser_in;
    logic [7:0] data_out;
    logic       ser_out;
    logic       busy;
    logic       done;

    logic       op_valid2;
    logic       op_ready2;
    logic [2:0] op_mode2;
    logic [3:0] op_count2;
    logic [7:0] load_data2;
    logic [1:0] ser_in2;
    logic [7:0] data_out2;
    logic [1:0] ser_out2;
    logic       busy2;
    logic       done2;

    int checks;
    int errors;

    localparam logic [2:0] M_NOP  = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_NOP7 = 3'b111;

    typedef struct packed {
        logic       valid;
        logic [2:0] mode;
        logic [3:0] count;
        logic [7:0] ldata;
        logic       ser;
        logic [7:0] exp_data;
        logic       exp_ready;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_ser;
    } vec_t;

    vec_t vecs[$];

    param_shift_register #(.WIDTH(8), .STEP(1), .CNT_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_mode   (op_mode),
        .op_count  (op_count),
        .load_data (load_data),
        .ser_in    (ser_in),
        .data_out  (data_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    param_shift_register #(.WIDTH(8), .STEP(2), .CNT_W(4)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_valid  (op_valid2),
        .op_ready  (op_ready2),
        .op_mode   (op_mode2),
        .op_count  (op_count2),
        .load_data (load_data2),
        .ser_in    (ser_in2),
        .data_out  (data_out2),
        .ser_out   (ser_out2),
        .busy      (busy2),
        .done      (done2)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(
        input logic       valid,
        input logic [2:0] mode,
        input logic [3:0] count,
        input logic [7:0] ldata,
        input logic       ser,
        input logic [7:0] exp_data,
        input logic       exp_ready,
        input logic       exp_busy,
        input logic       exp_done,
        input logic       exp_ser
    );
        vec_t v;
        v.valid     = valid;
        v.mode      = mode;
        v.count     = count;
        v.ldata     = ldata;
        v.ser       = ser;
        v.exp_data  = exp_data;
        v.exp_ready = exp_ready;
        v.exp_busy  = exp_busy;
        v.exp_done  = exp_done;
        v.exp_ser   = exp_ser;
        return v;
    endfunction

    task automatic applyStimulus(
        input logic       valid,
        input logic [2:0] mode,
        input logic [3:0] count,
        input logic [7:0] ldata,
        input logic       ser
    );
        op_valid  = valid;
        op_mode   = mode;
        op_count  = count;
        load_data = ldata;
        ser_in    = ser;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        applyStimulus(1'b0, M_NOP, 4'd0, 8'h00, 1'b0);
        op_valid2  = 1'b0;
        op_mode2   = M_NOP;
        op_count2  = 4'd0;
        load_data2 = 8'h00;
        ser_in2    = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset data_out", 32'(data_out), 32'h00);
        checkOutput("reset op_ready", 32'(op_ready), 32'h1);
        checkOutput("reset busy",     32'(busy),     32'h0);
        checkOutput("reset done",     32'(done),     32'h0);
        reset_n = 1'b1;

        // valid, mode, count, load, ser | data, ready, busy, done, ser_out
        vecs.push_back(mkVec(1, M_LOAD, 4'd0, 8'hA5, 0, 8'hA5, 1, 0, 1, 1));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'hA5, 1, 0, 0, 1));
        vecs.push_back(mkVec(1, M_SHL,  4'd3, 8'h00, 1, 8'h4B, 0, 1, 0, 0));
        vecs.push_back(mkVec(1, M_LOAD, 4'd0, 8'h00, 1, 8'h97, 0, 1, 0, 1));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 1, 8'h2F, 1, 0, 1, 0));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'h2F, 1, 0, 0, 0));
        vecs.push_back(mkVec(1, M_LOAD, 4'd0, 8'h80, 0, 8'h80, 1, 0, 1, 1));
        vecs.push_back(mkVec(1, M_ASR,  4'd2, 8'h00, 0, 8'hC0, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'hE0, 1, 0, 1, 0));
        vecs.push_back(mkVec(1, M_LOAD, 4'd0, 8'h3C, 0, 8'h3C, 1, 0, 1, 0));
        vecs.push_back(mkVec(1, M_ROR,  4'd8, 8'h00, 0, 8'h1E, 0, 1, 0, 0));
        vecs.push_back(mkVec(1, M_SHL,  4'd1, 8'hFF, 1, 8'h0F, 0, 1, 0, 1));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'h87, 0, 1, 0, 1));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'hC3, 0, 1, 0, 1));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'hE1, 0, 1, 0, 1));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'hF0, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'h78, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'h3C, 1, 0, 1, 0));
        vecs.push_back(mkVec(1, M_SHL,  4'd0, 8'h00, 1, 8'h3C, 1, 0, 1, 0));
        vecs.push_back(mkVec(1, M_NOP7, 4'd5, 8'hFF, 1, 8'h3C, 1, 0, 1, 0));
        vecs.push_back(mkVec(1, M_ROL,  4'd1, 8'h00, 0, 8'h78, 1, 0, 1, 0));
        vecs.push_back(mkVec(1, M_SHR,  4'd1, 8'h00, 1, 8'hBC, 1, 0, 1, 0));
        vecs.push_back(mkVec(0, M_NOP,  4'd0, 8'h00, 0, 8'hBC, 1, 0, 0, 0));

        // Table-driven single-cycle vectors: drive on negedge, check next negedge
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].mode, vecs[i].count, vecs[i].ldata, vecs[i].ser);
            @(negedge clk);
            checkOutput($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d op_ready", i), 32'(op_ready), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d busy", i),     32'(busy),     32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d done", i),     32'(done),     32'(vecs[i].exp_done));
            checkOutput($sformatf("vec%0d ser_out", i),  32'(ser_out),  32'(vecs[i].exp_ser));
        end

        // Reset in the middle of an SHL count=5 burst on 0xBC
        applyStimulus(1'b1, M_SHL, 4'd5, 8'h00, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, M_NOP, 4'd0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("midburst data before reset", 32'(data_out), 32'hF0);
        checkOutput("midburst busy before reset", 32'(busy),     32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("midburst reset data_out", 32'(data_out), 32'h00);
        checkOutput("midburst reset op_ready", 32'(op_ready), 32'h1);
        checkOutput("midburst reset busy",     32'(busy),     32'h0);
        checkOutput("midburst reset done",     32'(done),     32'h0);
        @(negedge clk);
        checkOutput("reset held done", 32'(done), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post reset done",     32'(done),     32'h0);
        checkOutput("post reset data_out", 32'(data_out), 32'h00);
        checkOutput("post reset op_ready", 32'(op_ready), 32'h1);

        // STEP=2 instance: LOAD 0xC1 then ROL count=1 gives 0x07
        op_valid2  = 1'b1;
        op_mode2   = M_LOAD;
        load_data2 = 8'hC1;
        @(negedge clk);
        checkOutput("step2 load data_out", 32'(data_out2), 32'hC1);
        checkOutput("step2 load ser_out",  32'(ser_out2),  32'h3);
        op_mode2   = M_ROL;
        op_count2  = 4'd1;
        @(negedge clk);
        op_valid2  = 1'b0;
        checkOutput("step2 rol data_out", 32'(data_out2), 32'h07);
        checkOutput("step2 rol done",     32'(done2),     32'h1);
        checkOutput("step2 rol op_ready", 32'(op_ready2), 32'h1);
        checkOutput("step2 rol ser_out",  32'(ser_out2),  32'h0);
        @(negedge clk);
        checkOutput("step2 done single pulse", 32'(done2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
